fft_twiddle_sequencer: RTL and testbench

- Initiator side of the twiddle factor ROM: walks a 512-point radix-2 DIT FFT through all stages and butterflies.
- Drives the ROM address, absorbs the ROM's 1-cycle read latency, and presents each butterfly to the butterfly unit over a valid/ready handshake.
- A butterfly presentation is the top/bottom sample indices, the stage number and the matching Q1.23 twiddle.
- Sits between the FFT control top level and the butterfly datapath; it has a stage barrier so a stage never starts before the previous one has drained.

---
 rtl/fft_pkg.sv | 19 +
 rtl/fft_bf_index_gen.sv | 29 ++
 rtl/fft_twiddle_sequencer.sv | 148 ++++++++++++++
 tb/tb_fft_twiddle_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and FSM encoding for the 512-point radix-2 FFT twiddle sequencer.
package fft_pkg;

  localparam int unsigned LOG2N      = 9;
  localparam int unsigned N          = 1 << LOG2N;
  localparam int unsigned DATA_W     = 48;
  localparam int unsigned PART_WIDTH = DATA_W / 2;

  // Q1.23 representation of +1.0 (saturated).
  localparam logic [PART_WIDTH-1:0] Q_ONE = 24'h7FFFFF;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StRun,
    StDrain
  } state_e;

endpackage

// File: rtl/fft_bf_index_gen.sv
// Combinational radix-2 DIT butterfly index generator: (stage, butterfly) -> (top, bot, k).
module fft_bf_index_gen #(
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned STAGE_WIDTH = 4
) (
  input  logic [STAGE_WIDTH-1:0] stage_i,
  input  logic [ADDR_WIDTH-2:0]  bfly_i,
  output logic [ADDR_WIDTH-1:0]  top_o,
  output logic [ADDR_WIDTH-1:0]  bot_o,
  output logic [ADDR_WIDTH-1:0]  k_o
);

  logic [ADDR_WIDTH-1:0] half;
  logic [ADDR_WIDTH-1:0] b_ext;
  logic [ADDR_WIDTH-1:0] j;
  logic [ADDR_WIDTH-1:0] grp;

  always_comb begin
    b_ext = {1'b0, bfly_i};
    half  = ADDR_WIDTH'(1) << stage_i;
    j     = b_ext & (half - 1'b1);
    grp   = b_ext >> stage_i;
    top_o = (grp << (stage_i + 1'b1)) | j;
    bot_o = top_o + half;
    // j < 2^stage, so k stays below N/2 and the MSB is always clear.
    k_o   = j << (STAGE_WIDTH'(ADDR_WIDTH - 1) - stage_i);
  end

endmodule

// File: rtl/fft_twiddle_sequencer.sv
// Walks all stages/butterflies of a radix-2 DIT FFT, fetching twiddles from a 1-cycle ROM
// and presenting each butterfly over valid/ready with a drain barrier between stages.
module fft_twiddle_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = LOG2N,
  parameter int unsigned DATA_WIDTH  = 2 * PART_WIDTH,
  parameter int unsigned STAGE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH-1:0]  tw_addr,
  input  logic [DATA_WIDTH-1:0]  tw_data,
  output logic                   bf_valid,
  input  logic                   bf_ready,
  output logic [ADDR_WIDTH-1:0]  bf_top,
  output logic [ADDR_WIDTH-1:0]  bf_bot,
  output logic [STAGE_WIDTH-1:0] bf_stage,
  output logic [DATA_WIDTH-1:0]  bf_twiddle,
  output logic                   bf_last,
  input  logic                   pipe_idle
);

  localparam int unsigned BfWidth = ADDR_WIDTH - 1;
  localparam logic [BfWidth-1:0] BfLast = '1;
  localparam logic [STAGE_WIDTH-1:0] StageLast = STAGE_WIDTH'(ADDR_WIDTH - 1);

  state_e                 state_q, state_d;
  logic [STAGE_WIDTH-1:0] stage_q, stage_d;
  logic [BfWidth-1:0]     bfly_q, bfly_d;
  logic [ADDR_WIDTH-1:0]  top_q, top_d, bot_q, bot_d, addr_q, addr_d;
  logic                   valid_q, valid_d, busy_q, busy_d, done_q, done_d, last_q, last_d;
  logic                   load;
  logic [ADDR_WIDTH-1:0]  idx_top, idx_bot, idx_k;

  fft_bf_index_gen #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .STAGE_WIDTH (STAGE_WIDTH)
  ) u_index_gen (
    .stage_i (stage_d),
    .bfly_i  (bfly_d),
    .top_o   (idx_top),
    .bot_o   (idx_bot),
    .k_o     (idx_k)
  );

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    last_d  = last_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A start coinciding with the done pulse belongs to the finished pass: drop it.
        if (start && !done_q) begin
          stage_d = '0;
          bfly_d  = '0;
          load    = 1'b1;
          busy_d  = 1'b1;
          state_d = StFill;
        end
      end
      StFill: begin
        valid_d = 1'b1;
        state_d = StRun;
      end
      StRun: begin
        if (valid_q && bf_ready) begin
          if (bfly_q != BfLast) begin
            bfly_d = bfly_q + 1'b1;
            load   = 1'b1;
          end else begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (pipe_idle) begin
          if (stage_q != StageLast) begin
            stage_d = stage_q + 1'b1;
            bfly_d  = '0;
            load    = 1'b1;
            state_d = StFill;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (load) begin
      last_d = (bfly_d == BfLast);
    end
    top_d  = load ? idx_top : top_q;
    bot_d  = load ? idx_bot : bot_q;
    addr_d = load ? idx_k : addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      stage_q <= '0;
      bfly_q  <= '0;
      top_q   <= '0;
      bot_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      bfly_q  <= bfly_d;
      top_q   <= top_d;
      bot_q   <= bot_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      last_q  <= last_d;
    end
  end

  // The ROM is fed the next-state address so its registered output lines up with the
  // descriptor after each edge; while stalled this is the held address.
  assign tw_addr    = addr_d;
  assign busy       = busy_q;
  assign done       = done_q;
  assign bf_valid   = valid_q;
  assign bf_top     = top_q;
  assign bf_bot     = bot_q;
  assign bf_stage   = stage_q;
  assign bf_last    = last_q;
  assign bf_twiddle = tw_data;

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Scoreboard bench for fft_twiddle_sequencer: stimulus pushes expected descriptors per pass,
// a negedge monitor compares every presented descriptor and pops on handshake.
module tb_fft_twiddle_sequencer;
  import fft_pkg::*;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 48;
  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          bf_ready = 1'b1;
  logic          pipe_idle = 1'b1;
  logic          busy, done, bf_valid, bf_last;
  logic [AW-1:0] tw_addr, bf_top, bf_bot;
  logic [DW-1:0] tw_data, bf_twiddle;
  logic [SW-1:0] bf_stage;

  typedef struct {
    logic [AW-1:0] top;
    logic [AW-1:0] bot;
    logic [SW-1:0] stage;
    logic          last;
    logic [AW-1:0] k;
    logic [DW-1:0] tw;
  } exp_t;

  typedef struct {
    int            idx;
    int            top;
    int            bot;
    int            stage;
    int            last;
    logic [DW-1:0] tw;
  } spot_t;

  // Hand-computed descriptors at fixed handshake positions within a full pass.
  spot_t spot [6] = '{
    '{0,    0,   1,   0, 0, 48'h7FFFFF_000000},
    '{1,    2,   3,   0, 0, 48'h7FFFFF_000000},
    '{255,  510, 511, 0, 1, 48'h7FFFFF_000000},
    '{259,  5,   7,   1, 0, 48'h000000_800000},
    '{2053, 5,   261, 8, 0, 48'h000005_0001FA},
    '{2303, 255, 511, 8, 1, 48'h0000FF_000100}
  };

  exp_t         sb_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           hs_cnt = 0;
  int           pass_base = 0;
  int           done_cnt = 0;
  int           stage_hs = 0;
  logic [N-1:0] cov = '0;
  logic         rand_ready = 1'b0;

  fft_twiddle_sequencer #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .STAGE_WIDTH (SW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .tw_addr    (tw_addr),
    .tw_data    (tw_data),
    .bf_valid   (bf_valid),
    .bf_ready   (bf_ready),
    .bf_top     (bf_top),
    .bf_bot     (bf_bot),
    .bf_stage   (bf_stage),
    .bf_twiddle (bf_twiddle),
    .bf_last    (bf_last),
    .pipe_idle  (pipe_idle)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    if (a == 9'd0) return {Q_ONE, 24'h000000};
    if (a == 9'd128) return 48'h000000_800000;
    return {15'h0, a, 15'h0, ~a};
  endfunction

  always @(posedge clk) tw_data <= rom_fn(tw_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_pass();
    for (int s = 0; s < 9; s++) begin
      int half;
      int groups;
      half   = 1 << s;
      groups = 256 / half;
      for (int g = 0; g < groups; g++) begin
        for (int j = 0; j < half; j++) begin
          exp_t e;
          e.top   = AW'(g * 2 * half + j);
          e.bot   = AW'(g * 2 * half + j + half);
          e.stage = SW'(s);
          e.last  = (g == groups - 1) && (j == half - 1);
          e.k     = AW'(j * groups);
          e.tw    = rom_fn(e.k);
          sb_q.push_back(e);
        end
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_hs(input int target, input int budget);
    int n = 0;
    while (hs_cnt < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("hs_wait", 64'(hs_cnt >= target), 64'(1));
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_wait", 64'(done), 64'(1));
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      bf_ready = rand_ready ? ($urandom_range(0, 99) >= 40) : 1'b1;
    end
  end

  // Monitor / scoreboard checker.
  initial begin
    exp_t e;
    int   idx;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cov = '0;
        stage_hs = 0;
      end else begin
        if (done) done_cnt++;
        if (bf_valid) begin
          chk("sb_pending", 64'(sb_q.size() != 0), 64'(1));
          if (sb_q.size() != 0) begin
            e = sb_q[0];
            chk("bf_top", 64'(bf_top), 64'(e.top));
            chk("bf_bot", 64'(bf_bot), 64'(e.bot));
            chk("bf_stage", 64'(bf_stage), 64'(e.stage));
            chk("bf_last", 64'(bf_last), 64'(e.last));
            chk("bf_twiddle", 64'(bf_twiddle), 64'(e.tw));
            if (!bf_ready) begin
              chk("tw_addr_stall", 64'(tw_addr), 64'(e.k));
            end else begin
              void'(sb_q.pop_front());
              idx = hs_cnt - pass_base;
              foreach (spot[i]) begin
                if (spot[i].idx == idx) begin
                  chk("spot_top", 64'(bf_top), 64'(spot[i].top));
                  chk("spot_bot", 64'(bf_bot), 64'(spot[i].bot));
                  chk("spot_stage", 64'(bf_stage), 64'(spot[i].stage));
                  chk("spot_last", 64'(bf_last), 64'(spot[i].last));
                  chk("spot_twiddle", 64'(bf_twiddle), 64'(spot[i].tw));
                end
              end
              cov[bf_top] = 1'b1;
              cov[bf_bot] = 1'b1;
              stage_hs++;
              hs_cnt++;
              if (bf_last) begin
                chk("stage_cover", 64'(&cov), 64'(1));
                chk("stage_count", 64'(stage_hs), 64'(256));
                cov = '0;
                stage_hs = 0;
              end
            end
          end
        end
      end
    end
  end

  initial begin
    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_valid", 64'(bf_valid), 64'(0));
    chk("rst_tw_addr", 64'(tw_addr), 64'(0));
    chk("rst_top", 64'(bf_top), 64'(0));
    chk("rst_bot", 64'(bf_bot), 64'(0));
    chk("rst_stage", 64'(bf_stage), 64'(0));
    chk("rst_last", 64'(bf_last), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Pass 1: ready high, pipe idle; check first-descriptor latency.
    push_pass();
    pass_base = hs_cnt;
    pulse_start();
    chk("p1_busy", 64'(busy), 64'(1));
    chk("p1_fill_valid", 64'(bf_valid), 64'(0));
    @(posedge clk); #1;
    chk("p1_first_valid", 64'(bf_valid), 64'(1));
    chk("p1_first_top", 64'(bf_top), 64'(0));
    chk("p1_first_bot", 64'(bf_bot), 64'(1));
    chk("p1_first_tw", 64'(bf_twiddle), 64'(48'h7FFFFF_000000));
    wait_done(8000);
    start = 1'b1;  // same cycle as done: must be ignored
    @(posedge clk); #1;
    start = 1'b0;
    chk("p1_hs", 64'(hs_cnt - pass_base), 64'(2304));
    chk("p1_done_cnt", 64'(done_cnt), 64'(1));
    chk("p1_sb_empty", 64'(sb_q.size()), 64'(0));
    repeat (3) begin
      @(posedge clk); #1;
      chk("start_on_done_busy", 64'(busy), 64'(0));
      chk("start_on_done_valid", 64'(bf_valid), 64'(0));
    end

    // Pass 2: random stalls, pipe not idle after stage 0 for 20 cycles.
    rand_ready = 1'b1;
    pipe_idle = 1'b0;
    push_pass();
    pass_base = hs_cnt;
    pulse_start();
    wait_hs(pass_base + 256, 8000);
    repeat (20) begin
      @(posedge clk); #1;
      chk("drain_hold_valid", 64'(bf_valid), 64'(0));
    end
    pipe_idle = 1'b1;
    @(posedge clk); #1;
    chk("drain_fill_valid", 64'(bf_valid), 64'(0));
    @(posedge clk); #1;
    chk("stage1_valid", 64'(bf_valid), 64'(1));
    chk("stage1_stage", 64'(bf_stage), 64'(1));
    wait_done(12000);
    @(posedge clk); #1;
    chk("p2_hs", 64'(hs_cnt - pass_base), 64'(2304));
    chk("p2_done_cnt", 64'(done_cnt), 64'(2));
    chk("p2_sb_empty", 64'(sb_q.size()), 64'(0));

    // Pass 3: asynchronous reset during stage 4.
    push_pass();
    pass_base = hs_cnt;
    pulse_start();
    wait_hs(pass_base + 4 * 256 + 37, 12000);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_valid", 64'(bf_valid), 64'(0));
    chk("arst_tw_addr", 64'(tw_addr), 64'(0));
    chk("arst_top", 64'(bf_top), 64'(0));
    chk("arst_bot", 64'(bf_bot), 64'(0));
    chk("arst_stage", 64'(bf_stage), 64'(0));
    chk("arst_last", 64'(bf_last), 64'(0));
    sb_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("arst_no_done", 64'(done_cnt), 64'(2));
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Pass 4: clean pass; a start while busy is ignored.
    push_pass();
    pass_base = hs_cnt;
    pulse_start();
    repeat (5) begin
      @(posedge clk); #1;
    end
    pulse_start();
    chk("p4_busy", 64'(busy), 64'(1));
    wait_done(12000);
    @(posedge clk); #1;
    chk("p4_hs", 64'(hs_cnt - pass_base), 64'(2304));
    chk("p4_done_cnt", 64'(done_cnt), 64'(3));
    chk("p4_sb_empty", 64'(sb_q.size()), 64'(0));
    chk("p4_idle_busy", 64'(busy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
